// File: rtl/seq_signed_divider_pkg.sv
// Shared definitions for the sequential signed divider: FSM state encoding and default width.
package seq_signed_divider_pkg;

   localparam int DIV_DEFAULT_W = 16;

   typedef enum logic [1:0] {
      DIV_IDLE  = 2'd0,
      DIV_CALC  = 2'd1,
      DIV_FIXUP = 2'd2
   } div_state_e;

endpackage

// File: rtl/seq_signed_divider_step.sv
// One restoring division stage: shift in the next dividend bit, trial-subtract the divisor,
// keep the difference when non-negative, otherwise restore.
module seq_signed_divider_step
   import seq_signed_divider_pkg::*;
#(
   parameter int W = DIV_DEFAULT_W
) (
   input  logic [W-1:0] i_rem,
   input  logic         i_bit,
   input  logic [W:0]   i_dvs,
   output logic [W-1:0] o_rem,
   output logic         o_qbit
);

   logic [W:0] w_shift;
   logic [W:0] w_diff;

   // Partial remainder stays below |divisor| <= 2^(W-1), so W+1 bits hold the trial sign.
   always_comb begin
      w_shift = {i_rem, i_bit};
      w_diff  = w_shift - i_dvs;
      if (w_diff[W]) begin
         o_qbit = 1'b0;
         o_rem  = w_shift[W-1:0];
      end else begin
         o_qbit = 1'b1;
         o_rem  = w_diff[W-1:0];
      end
   end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider (restoring, one bit per clock, fixed W+1 edge latency).
// Define DIV_SAT_EN to saturate the most-negative / -1 overflow and flag it on o_err.
module seq_signed_divider
   import seq_signed_divider_pkg::*;
#(
   parameter int W = DIV_DEFAULT_W
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_start,
   input  logic [W-1:0] i_dividend,
   input  logic [W-1:0] i_divisor,
   output logic         o_busy,
   output logic         o_done,
   output logic [W-1:0] o_quotient,
   output logic [W-1:0] o_remainder,
   output logic         o_err
);

   localparam int                CNT_W    = $clog2(W);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(W - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [W-1:0]      ONE_W    = {{(W-1){1'b0}}, 1'b1};
`ifdef DIV_SAT_EN
   localparam logic [W-1:0]      MAX_POS  = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0]      MIN_NEG  = {1'b1, {(W-1){1'b0}}};
`endif

   function automatic logic [W-1:0] neg_w(input logic [W-1:0] v);
      return ~v + ONE_W;
   endfunction

   div_state_e       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [W-1:0]     r_q;
   logic [W-1:0]     r_rem;
   logic [W-1:0]     r_dvd_raw;
   logic [W:0]       r_dvs_mag;
   logic             r_sign_q;
   logic             r_sign_r;
   logic             r_div0;
   logic             r_busy;
   logic             r_done;
   logic             r_err;
   logic [W-1:0]     r_quo;
   logic [W-1:0]     r_rmd;
`ifdef DIV_SAT_EN
   logic             r_ovf;
`endif

   logic [W-1:0]     w_dvd_mag;
   logic [W:0]       w_dvs_mag;
   logic [W-1:0]     w_step_rem;
   logic             w_qbit;

   // Operand magnitudes; |-2^(W-1)| fits as an unsigned W-bit value.
   always_comb begin
      w_dvd_mag = i_dividend[W-1] ? neg_w(i_dividend) : i_dividend;
      w_dvs_mag = {1'b0, (i_divisor[W-1] ? neg_w(i_divisor) : i_divisor)};
   end

   seq_signed_divider_step #(.W(W)) u_step (
      .i_rem  (r_rem),
      .i_bit  (r_q[W-1]),
      .i_dvs  (r_dvs_mag),
      .o_rem  (w_step_rem),
      .o_qbit (w_qbit)
   );

   // Control FSM, iteration datapath and registered result/status outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= DIV_IDLE;
         r_cnt     <= '0;
         r_q       <= '0;
         r_rem     <= '0;
         r_dvd_raw <= '0;
         r_dvs_mag <= '0;
         r_sign_q  <= 1'b0;
         r_sign_r  <= 1'b0;
         r_div0    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_quo     <= '0;
         r_rmd     <= '0;
`ifdef DIV_SAT_EN
         r_ovf     <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            DIV_IDLE: begin
               if (i_start) begin
                  r_q       <= w_dvd_mag;
                  r_rem     <= '0;
                  r_dvd_raw <= i_dividend;
                  r_dvs_mag <= w_dvs_mag;
                  r_sign_q  <= i_dividend[W-1] ^ i_divisor[W-1];
                  r_sign_r  <= i_dividend[W-1];
                  r_div0    <= (i_divisor == '0);
`ifdef DIV_SAT_EN
                  r_ovf     <= (i_dividend == MIN_NEG) && (i_divisor == '1);
`endif
                  r_cnt     <= CNT_LOAD;
                  r_busy    <= 1'b1;
                  r_state   <= DIV_CALC;
               end
            end
            DIV_CALC: begin
               r_rem <= w_step_rem;
               r_q   <= {r_q[W-2:0], w_qbit};
               if (r_cnt == '0) begin
                  r_state <= DIV_FIXUP;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            DIV_FIXUP: begin
               if (r_div0) begin
                  r_quo <= '1;
                  r_rmd <= r_dvd_raw;
                  r_err <= 1'b1;
`ifdef DIV_SAT_EN
               end else if (r_ovf) begin
                  r_quo <= MAX_POS;
                  r_rmd <= '0;
                  r_err <= 1'b1;
`endif
               end else begin
                  // Without saturation, MIN/-1 wraps naturally: magnitude 2^(W-1) reads as MIN.
                  r_quo <= r_sign_q ? neg_w(r_q) : r_q;
                  r_rmd <= r_sign_r ? neg_w(r_rem) : r_rem;
                  r_err <= 1'b0;
               end
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= DIV_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= DIV_IDLE;
            end
         endcase
      end
   end

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_quotient  = r_quo;
   assign o_remainder = r_rmd;
   assign o_err       = r_err;

endmodule
